// File: rtl/alu_pkg.sv
// Shared op-code and output-slot state encodings for the shared ALU arbiter.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Requester index width; a single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared ALU arbiter and its result consumer.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_carry;
  logic [IDW-1:0]        rsp_id;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
  );

endinterface

// File: rtl/alu_op_unit.sv
// Combinational AND/OR/XOR/ADD datapath; carry is the sum's top bit for ADD and 0 otherwise.
module alu_op_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU among NREQ requesters; result registered one edge after grant.
// Grants only while the output slot is empty or draining, so a stalled consumer stalls all requesters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int IDW = id_width(NREQ);
  localparam int SW  = IDW + 1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic             can_accept;
  logic             found;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic [SW-1:0]    probe;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;

  // Scan upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    for (int off = 0; off < NREQ; off++) begin
      probe = {1'b0, rr_ptr_q} + SW'(off);
      if (probe >= SW'(NREQ)) begin
        probe = probe - SW'(NREQ);
      end
      if (!found && bus.req_valid[probe[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = probe[IDW-1:0];
      end
    end
  end

  assign gnt_vld = found && can_accept;

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ready = rst_n ? gnt_oh : '0;

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op = bus.req_op[2*i +: 2];
        sel_a  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  alu_op_unit #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // A grant always (re)fills the slot, which also covers drain-and-refill in one cycle.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    carry_d  = carry_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      state_d = ST_FULL;
      data_d  = alu_res;
      carry_d = alu_carry;
      id_d    = gnt_idx;
      if (gnt_idx == IDW'(NREQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + IDW'(1);
      end
    end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and random stimulus for alu_share_arbiter; a predictor queues expected results, a monitor pops them on consume.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic        carry;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rsp_ready = 1'b1;
  logic [3:0]  vld = '0;
  logic [1:0]  op_r [NREQ];
  logic [31:0] a_r  [NREQ];
  logic [31:0] b_r  [NREQ];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_rr    = 0;
  bit   m_valid = 1'b0;
  logic [3:0] acc_mask = '0;
  exp_t q [$];

  alu_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.req_valid = vld;
  assign bus.rsp_ready = rsp_ready;

  always_comb begin
    bus.req_op = '0;
    bus.req_a  = '0;
    bus.req_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[2*i +: 2]        = op_r[i];
      bus.req_a[WIDTH*i +: WIDTH] = a_r[i];
      bus.req_b[WIDTH*i +: WIDTH] = b_r[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  function automatic logic [32:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Predictor: reference arbiter decides the grant and queues the expected result.
  always @(negedge clk) begin
    logic [3:0]  exp_rdy;
    logic [32:0] r;
    exp_t        e;
    int          gnt;
    int          idx;
    if (!rst_n) begin
      m_rr    = 0;
      m_valid = 1'b0;
      q.delete();
    end else begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      exp_rdy = '0;
      gnt     = -1;
      if (!m_valid || rsp_ready) begin
        for (int off = 0; off < NREQ; off++) begin
          idx = (m_rr + off) % NREQ;
          if (gnt < 0 && vld[idx]) gnt = idx;
        end
      end
      if (gnt >= 0) exp_rdy[gnt] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      acc_mask = exp_rdy;
      if (gnt >= 0) begin
        r       = ref_alu(op_r[gnt], a_r[gnt], b_r[gnt]);
        e.id    = 2'(gnt);
        e.carry = r[32];
        e.data  = r[31:0];
        q.push_back(e);
        m_rr    = (gnt + 1) % NREQ;
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: every consumed result must be the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_result", 64'(bus.rsp_data), 64'hDEAD_0000_0000_0000);
      end else begin
        e = q.pop_front();
        chk("sb_result", {29'h0, bus.rsp_id, bus.rsp_carry, bus.rsp_data},
            {29'h0, e.id, e.carry, e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_r[i] = op;
    a_r[i]  = a;
    b_r[i]  = b;
  endtask

  initial begin
    int seq_all [5];
    int seq_skip [4];
    int accepted;
    int cycles;
    seq_all  = '{0, 1, 2, 3, 0};
    seq_skip = '{0, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'h0, 32'h0);

    // Power-on reset with all requesters asserting.
    vld = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_data",  64'(bus.rsp_data),  64'h0);
    chk("rst_rsp_carry", 64'(bus.rsp_carry), 64'h0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'h0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    vld = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Single OR from requester 2.
    set_req(2, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F);
    vld = 4'b0100;
    #1 chk("single_req_ready", 64'(bus.req_ready), 64'h4);
    cyc();
    chk("single_valid", 64'(bus.rsp_valid), 64'h1);
    chk("single_data",  64'(bus.rsp_data),  64'hF0F0_0F0F);
    chk("single_id",    64'(bus.rsp_id),    64'h2);
    chk("single_carry", 64'(bus.rsp_carry), 64'h0);
    vld = '0;
    cyc();
    chk("drain_valid", 64'(bus.rsp_valid), 64'h0);
    chk("drain_hold_data", 64'(bus.rsp_data), 64'hF0F0_0F0F);

    // ADD overflow from requester 0 (pointer at 3 wraps to 0), then AND from requester 1.
    set_req(0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001);
    vld = 4'b0001;
    cyc();
    chk("add_data",  64'(bus.rsp_data),  64'h0);
    chk("add_carry", 64'(bus.rsp_carry), 64'h1);
    chk("add_id",    64'(bus.rsp_id),    64'h0);
    set_req(1, 2'b00, 32'hFF00_FF00, 32'h0FF0_0FF0);
    vld = 4'b0010;
    cyc();
    chk("and_data",  64'(bus.rsp_data),  64'h0F00_0F00);
    chk("and_carry", 64'(bus.rsp_carry), 64'h0);
    chk("and_id",    64'(bus.rsp_id),    64'h1);
    vld = '0;
    cyc();

    // Backpressure: slot held for 5 cycles, then drain and next grant in one cycle.
    rsp_ready = 1'b0;
    set_req(2, 2'b10, 32'h1234_5678, 32'hFFFF_0000);
    set_req(3, 2'b11, 32'h0000_0005, 32'h0000_000A);
    vld = 4'b1100;
    cyc();
    chk("bp_first_id",   64'(bus.rsp_id),   64'h2);
    chk("bp_first_data", 64'(bus.rsp_data), 64'hEDCB_5678);
    vld = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_req_ready", 64'(bus.req_ready), 64'h0);
      chk("bp_valid",     64'(bus.rsp_valid), 64'h1);
      chk("bp_data",      64'(bus.rsp_data),  64'hEDCB_5678);
      chk("bp_id",        64'(bus.rsp_id),    64'h2);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_req_ready", 64'(bus.req_ready), 64'h8);
    cyc();
    chk("bp_next_id",   64'(bus.rsp_id),   64'h3);
    chk("bp_next_data", 64'(bus.rsp_data), 64'h0000_000F);
    vld = '0;
    cyc();

    // Reset while FULL with requester 2's result in the slot.
    set_req(2, 2'b01, 32'hA5A5_A5A5, 32'h0);
    vld = 4'b0100;
    cyc();
    chk("mid_full_id", 64'(bus.rsp_id), 64'h2);
    vld = '0;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'h0);
    chk("mid_rst_data",  64'(bus.rsp_data),  64'h0);
    chk("mid_rst_id",    64'(bus.rsp_id),    64'h0);
    cyc();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 32'h1111_1111 * i, 32'h0F0F_0F0F);
    vld = 4'b1111;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("post_rst_first_grant", 64'(bus.req_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_all_id", 64'(bus.rsp_id), 64'(seq_all[k]));
    end

    // Round robin with requester 1 idle, from a fresh pointer.
    rst_n = 1'b0;
    vld = 4'b1101;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_skip_id", 64'(bus.rsp_id), 64'(seq_skip[k]));
    end
    vld = '0;
    cyc(); cyc();

    // Random ops, operands, valid patterns and consumer stalls.
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 8000) begin
      cyc();
      cycles++;
      accepted += $countones(acc_mask);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i] || !vld[i]) begin
          vld[i] = ($urandom_range(0, 2) != 0);
          set_req(i, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    vld = '0;
    rsp_ready = 1'b1;
    repeat (3) cyc();
    chk("random_accepted", 64'(accepted >= 1000), 64'h1);
    chk("sb_drained", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit ALU operation unit (AND / OR / XOR / ADD) between NREQ requesters. Each requester presents an operation and operands with a valid/ready handshake. The block grants one requester per cycle, computes the result and holds it in a single registered output slot tagged with the requester index until the consumer accepts it. It sits between the instruction-issue logic of several clients and the shared bitwise/arithmetic datapath.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥1).
- NREQ, 4, number of requesters (2..16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i presents an operation.
- req_ready  output  NREQ  bit i: requester i accepted this cycle (one-hot or zero).
- req_op  input  2*NREQ  op of requester i in bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 ADD.
- req_a  input  WIDTH*NREQ  operand A of requester i in bits [WIDTH*i +: WIDTH].
- req_b  input  WIDTH*NREQ  operand B of requester i, same packing.
- rsp_valid  output  1  result slot holds a valid result.
- rsp_ready  input  1  consumer accepts the result this cycle.
- rsp_data  output  WIDTH  result.
- rsp_carry  output  1  carry-out for ADD; 0 for logic ops.
- rsp_id  output  clog2(NREQ) (min 1)  index of the requester that produced the result.

## Operation
- Output slot FSM has two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- `can_accept = !rsp_valid || rsp_ready`.
- Grant: when `can_accept` and any req_valid bit is set, grant the first set bit searching upward from `rr_ptr`, wrapping at NREQ-1 to 0.
  - req_ready is asserted only for the granted bit, combinationally in the same cycle.
  - req_ready never asserts for a bit whose req_valid is 0.
- On a grant at edge k:
  - rsp_data, rsp_carry and rsp_id load the computed result; state becomes FULL.
  - rr_ptr becomes (granted+1) mod NREQ.
- If there is no grant while `rsp_ready` and FULL: state goes to EMPTY. rsp_data/rsp_id/rsp_carry keep their last values.
- If FULL and `!rsp_ready`: all outputs are held stable and req_ready is all-zero (backpressure).
- Simultaneous drain and grant in one cycle: the old result is consumed and the new result is loaded; state stays FULL. This sustains 1 op/cycle.
- Arithmetic:
  - AND, OR and XOR are bitwise over WIDTH bits.
  - ADD is modulo 2^WIDTH, with rsp_carry = bit WIDTH of the (WIDTH+1)-bit sum.
- rsp_ready while EMPTY has no effect.
- Requesters must hold req_valid/op/operands until they see req_ready; the block does not latch unaccepted requests.

## Timing
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, rr_ptr=0, state EMPTY.
  - req_ready=0 while rst_n is low.
- Reset mid-operation discards any held result; no partial output is visible after release.
- Latency: a request accepted at edge k gives rsp_valid=1 with its result from edge k (visible cycle k+1).
- Throughput: 1 result per cycle with rsp_ready held high.
- Fairness: with all NREQ requesting continuously and no backpressure, grant order is 0,1,…,NREQ-1,0,…. No requester waits more than NREQ-1 grants.

## Structure
- Shared package (alu_pkg): op-code constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11, and the state encoding EMPTY/FULL.
- Sub-module alu_op_unit (combinational): inputs op, a, b; outputs result and carry. It is the only datapath instance; all requesters share it through the grant mux.
- Top level contains the round-robin pointer, the priority search, the operand mux and the output register/FSM.

## Test plan
- Reset mid-FULL:
  - Assert rst_n=0 while rsp_valid=1 -> rsp_valid, rsp_data, rsp_id drop to 0 immediately without a clock.
  - After release, the first grant goes to requester 0.
- Single op: requester 2 issues OR with a=0xF0F0_0000, b=0x0000_0F0F, NREQ=4 -> req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_data=0xF0F0_0F0F, rsp_id=2, rsp_carry=0.
- ADD overflow: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_data=0, rsp_carry=1; AND 0xFF00_FF00 with 0x0FF0_0FF0 -> 0x0F00_0F00, carry 0.
- Round robin:
  - All 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0.
  - Drop requester 1 -> sequence skips it: 0,2,3,0.
- Backpressure: hold rsp_ready=0 for 5 cycles with results pending -> rsp_* outputs stable, req_ready=0. Raise rsp_ready -> next requester is granted in the same cycle as the drain; no result is lost or duplicated.
- Back-to-back random: 1000 random ops/operands/valid patterns with random rsp_ready, checked against a reference model -> every accepted op appears exactly once, in acceptance order, with the correct rsp_id, data and carry.
